// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous memory between the CPU fetch and data ports.
// Data has fixed priority; fetch is forced through after STARVE_LIMIT consecutive losses.
module mips_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic [31:0] m_addr,
    output logic        m_re,
    output logic        m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        grant_d
);

    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] starve_reg, starve_next;
    logic [31:0]   m_addr_reg, m_addr_next;
    logic [31:0]   m_wdata_reg, m_wdata_next;
    logic          m_re_reg, m_re_next;
    logic          m_we_reg, m_we_next;
    logic          grant_reg, grant_next;
    logic          fetch_forced;
    logic          pick_d;

    assign fetch_forced = (STARVE_LIMIT != 0) && (starve_reg == LIMIT_C);
    assign pick_d       = d_req && !(i_req && fetch_forced);

    always_comb begin
        state_next   = state_reg;
        starve_next  = starve_reg;
        m_addr_next  = m_addr_reg;
        m_wdata_next = m_wdata_reg;
        m_re_next    = 1'b0;
        m_we_next    = 1'b0;
        grant_next   = grant_reg;
        case (state_reg)
            S_IDLE: begin
                if (pick_d) begin
                    m_addr_next  = d_addr;
                    m_wdata_next = d_wdata;
                    m_re_next    = !d_we;
                    m_we_next    = d_we;
                    grant_next   = 1'b1;
                    state_next   = S_ACCESS;
                end else if (i_req) begin
                    m_addr_next = i_addr;
                    m_re_next   = 1'b1;
                    grant_next  = 1'b0;
                    state_next  = S_ACCESS;
                end
                // Only a data win over a waiting fetch counts as a loss.
                if (i_req && pick_d) begin
                    if (starve_reg != CNT_MAX) begin
                        starve_next = starve_reg + 1'b1;
                    end
                end else begin
                    starve_next = '0;
                end
            end
            S_ACCESS: state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            starve_reg  <= '0;
            m_addr_reg  <= '0;
            m_wdata_reg <= '0;
            m_re_reg    <= 1'b0;
            m_we_reg    <= 1'b0;
            grant_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            starve_reg  <= starve_next;
            m_addr_reg  <= m_addr_next;
            m_wdata_reg <= m_wdata_next;
            m_re_reg    <= m_re_next;
            m_we_reg    <= m_we_next;
            grant_reg   <= grant_next;
        end
    end

    // Ready decodes straight from state so an asynchronous reset kills it at once.
    assign i_ready = (state_reg == S_RESP) && !grant_reg;
    assign d_ready = (state_reg == S_RESP) && grant_reg;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;
    assign m_re    = m_re_reg;
    assign m_we    = m_we_reg;
    assign grant_d = grant_reg;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Randomized and directed bench for mips_mem_arbiter: drivers push expected responses,
// a negedge monitor pops and compares them on every ready pulse.
module tb_mips_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, d_ready, grant_d, m_re, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic [31:0] m_rdata;

    logic        n_i_req, n_d_req;
    logic        n_i_ready, n_d_ready, n_grant_d, n_m_re, n_m_we;
    logic [31:0] n_i_rdata, n_d_rdata, n_m_addr, n_m_wdata;
    logic [31:0] n_m_rdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mips_mem_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .grant_d(grant_d)
    );

    mips_mem_arbiter #(.STARVE_LIMIT(0)) u_nostarve (
        .clk(clk), .reset(reset),
        .i_req(n_i_req), .i_addr(32'h0000_1000), .i_ready(n_i_ready), .i_rdata(n_i_rdata),
        .d_req(n_d_req), .d_we(1'b0), .d_addr(32'h0000_0020), .d_wdata(32'h0),
        .d_ready(n_d_ready), .d_rdata(n_d_rdata),
        .m_addr(n_m_addr), .m_re(n_m_re), .m_we(n_m_we), .m_wdata(n_m_wdata),
        .m_rdata(n_m_rdata), .grant_d(n_grant_d)
    );
    assign n_m_rdata = 32'h0;

    function automatic logic [31:0] init_word(input int k);
        if (k == 1) return 32'h2402_0005;
        return (32'(k) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Unified memory seen by the DUT: registered read, unwritten words keep their init pattern.
    logic [31:0] mem [0:1023];
    bit          written [0:1023];
    always @(posedge clk) begin
        if (m_we) begin
            mem[m_addr[11:2]]     <= m_wdata;
            written[m_addr[11:2]] <= 1'b1;
        end
        if (m_re) begin
            m_rdata <= written[m_addr[11:2]] ? mem[m_addr[11:2]] : init_word(int'(m_addr[11:2]));
        end
    end

    // Reference memory, updated in issue order by the data driver.
    logic [31:0] ref_mem [0:1023];

    typedef struct {
        logic        we;
        logic [31:0] data;
    } dexp_t;

    dexp_t       dq[$];
    logic [31:0] iq[$];
    bit          grant_log[$];
    int          last_i_cyc, last_d_cyc;

    task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) report(name, act, exp);
    endtask

    // Monitor: pops expectations on every ready pulse.
    initial begin
        logic  prev_re, prev_we;
        int    d_since;
        dexp_t e;
        prev_re = 1'b0; prev_we = 1'b0; d_since = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_re = 1'b0; prev_we = 1'b0; d_since = 0;
            end else begin
                if (m_re || m_we) begin
                    check("strobe_exclusive", 32'(m_re && m_we), 32'd0);
                    check("strobe_width", 32'((m_re && prev_re) || (m_we && prev_we)), 32'd0);
                end
                prev_re = m_re; prev_we = m_we;
                if (d_ready) begin
                    check("d_ready_alone", 32'(i_ready), 32'd0);
                    check("d_grant", 32'(grant_d), 32'd1);
                    checks++;
                    if (dq.size() == 0) begin
                        report("d_ready_spurious", 32'(d_ready), 32'd0);
                    end else begin
                        e = dq.pop_front();
                        $display("data %s rdata=0x%08h cycle %0d", e.we ? "write" : "read ", d_rdata, cyc);
                        if (!e.we && d_rdata !== e.data) report("d_rdata", d_rdata, e.data);
                    end
                    grant_log.push_back(1'b1);
                    last_d_cyc = cyc;
                    if (i_req) begin
                        d_since++;
                        check("fetch_starvation", 32'(d_since > LIMIT + 1), 32'd0);
                    end
                end
                if (i_ready) begin
                    check("i_grant", 32'(grant_d), 32'd0);
                    checks++;
                    if (iq.size() == 0) begin
                        report("i_ready_spurious", 32'(i_ready), 32'd0);
                    end else begin
                        logic [31:0] x;
                        x = iq.pop_front();
                        $display("fetch rdata=0x%08h cycle %0d", i_rdata, cyc);
                        if (i_rdata !== x) report("i_rdata", i_rdata, x);
                    end
                    grant_log.push_back(1'b0);
                    last_i_cyc = cyc;
                    d_since = 0;
                end
                if (!i_req) d_since = 0;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] addr, input int exp_lat, input bit drop);
        int n;
        bit seen;
        n = 0; seen = 1'b0;
        iq.push_back(ref_mem[addr[11:2]]);
        i_addr = addr;
        i_req  = 1'b1;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (exp_lat != 0 && n == 1) begin
                check("fetch_m_re", 32'(m_re), 32'd1);
                check("fetch_m_addr", m_addr, addr);
            end
            if (i_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            report("fetch_timeout", 32'(n), 32'(exp_lat));
        end else if (exp_lat != 0) begin
            check("fetch_latency", 32'(n), 32'(exp_lat));
            check("fetch_no_d_ready", 32'(d_ready), 32'd0);
        end
        @(posedge clk); #1;
        if (drop) i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input bit drop);
        int    n;
        bit    seen;
        dexp_t e;
        n = 0; seen = 1'b0;
        e.we   = we;
        e.data = we ? 32'h0 : ref_mem[addr[11:2]];
        dq.push_back(e);
        if (we) ref_mem[addr[11:2]] = wdata;
        d_we = we; d_addr = addr; d_wdata = wdata;
        d_req = 1'b1;
        while (!seen && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (exp_lat != 0 && n == 1) begin
                check("data_m_we", 32'(m_we), 32'(we));
                check("data_m_re", 32'(m_re), 32'(!we));
                check("data_m_addr", m_addr, addr);
                if (we) check("data_m_wdata", m_wdata, wdata);
            end
            if (d_ready) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            report("data_timeout", 32'(n), 32'(exp_lat));
        end else if (exp_lat != 0) begin
            check("data_latency", 32'(n), 32'(exp_lat));
        end
        @(posedge clk); #1;
        if (drop) d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int          nd, ni, gap;
        logic [31:0] a;
        bit          exp_log[$];
        bit          we;
        for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);
        reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        n_i_req = 1'b0; n_d_req = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {30'h0, m_re, m_we}, 32'h0);
        check("rst_ready", {30'h0, i_ready, d_ready}, 32'h0);
        check("rst_grant", 32'(grant_d), 32'h0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_wdata", m_wdata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Fetch only, data write then read-back
        do_fetch(32'hBFC0_0004, 2, 1'b1);
        do_data(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 2, 1'b1);
        do_data(1'b0, 32'h0000_0008, 32'h0, 2, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Simultaneous requests: data first, fetch three cycles later
        grant_log.delete();
        fork
            do_fetch(32'h0000_0A40, 0, 1'b1);
            do_data(1'b0, 32'h0000_0100, 32'h0, 2, 1'b1);
        join
        check("simul_spacing", 32'(last_i_cyc - last_d_cyc), 32'd3);
        check("simul_log_len", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            check("simul_first_data", 32'(grant_log[0]), 32'd1);
            check("simul_then_fetch", 32'(grant_log[1]), 32'd0);
        end
        repeat (2) @(posedge clk); #1;

        // Starvation guard: fetch held, data reissued back to back
        begin
            int  losses, data_left;
            bit  fetch_pending;
            losses = 0; data_left = 5; fetch_pending = 1'b1;
            exp_log.delete();
            while (fetch_pending || data_left > 0) begin
                if (data_left > 0 && !(fetch_pending && losses == LIMIT)) begin
                    exp_log.push_back(1'b1);
                    data_left--;
                    if (fetch_pending) losses++;
                end else begin
                    exp_log.push_back(1'b0);
                    fetch_pending = 1'b0;
                    losses = 0;
                end
            end
        end
        grant_log.delete();
        fork
            do_fetch(32'h0000_0B00, 0, 1'b1);
            for (int k = 0; k < 5; k++) do_data(1'b0, 32'h0000_0040 + 32'(4 * k), 32'h0, 0, k == 4);
        join
        check("starve_log_len", 32'(grant_log.size()), 32'(exp_log.size()));
        for (int k = 0; k < exp_log.size() && k < grant_log.size(); k++) begin
            check($sformatf("starve_grant_%0d", k), 32'(grant_log[k]), 32'(exp_log[k]));
        end
        repeat (2) @(posedge clk); #1;

        // STARVE_LIMIT=0: fetch never wins while data keeps requesting
        nd = 0; ni = 0;
        n_i_req = 1'b1; n_d_req = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (n_d_ready) nd++;
            if (n_i_ready) ni++;
        end
        n_d_req = 1'b0;
        check("nostarve_fetch_wins", 32'(ni), 32'd0);
        check("nostarve_data_served", 32'(nd >= 9), 32'd1);
        repeat (4) @(posedge clk);
        n_i_req = 1'b0;
        repeat (4) @(posedge clk); #1;

        // Reset pulse in the middle of a data read
        d_we = 1'b0; d_addr = 32'h0000_0040; d_req = 1'b1;
        @(posedge clk); #1;
        check("rstmid_access_m_re", 32'(m_re), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("rstmid_m_re_async", 32'(m_re), 32'd0);
        check("rstmid_grant_async", 32'(grant_d), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rstmid_no_ready", {30'h0, i_ready, d_ready}, 32'h0);
        end
        begin
            dexp_t e;
            int    n;
            e.we = 1'b0; e.data = ref_mem[16];
            dq.push_back(e);
            @(negedge clk) reset = 1'b0;
            n = 0;
            while (!d_ready && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            check("rstmid_resume_latency", 32'(n), 32'd2);
            @(posedge clk); #1;
            d_req = 1'b0;
        end
        repeat (2) @(posedge clk);

        // Quiet bus with no requests
        repeat (20) begin
            @(negedge clk);
            check("idle_quiet", {28'h0, m_re, m_we, i_ready, d_ready}, 32'h0);
        end

        // Randomized concurrent traffic
        fork
            begin
                int          g;
                logic [31:0] fa;
                for (int k = 0; k < 40; k++) begin
                    g  = $urandom_range(0, 3);
                    fa = $urandom;
                    fa[11] = 1'b1; fa[1:0] = 2'b00;
                    do_fetch(fa, 0, g != 0);
                    repeat (g) @(posedge clk);
                end
                #1 i_req = 1'b0;
            end
            begin
                int          g;
                logic [31:0] da;
                for (int k = 0; k < 40; k++) begin
                    g  = $urandom_range(0, 3);
                    da = $urandom;
                    da[11] = 1'b0; da[1:0] = 2'b00;
                    we = 1'($urandom_range(0, 1));
                    do_data(we, da, $urandom, 0, g != 0);
                    repeat (g) @(posedge clk);
                end
                #1 d_req = 1'b0;
            end
        join
        gap = 0;
        a = 32'h0;
        repeat (6) @(posedge clk); #1;
        check("iq_drained", 32'(iq.size()), 32'd0);
        check("dq_drained", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
